ifu: RTL
========

# ifu

Instruction fetch unit: generates sequential fetch addresses, issues them on the instruction-memory request bus, and buffers in-order responses in a small FIFO. Each buffered entry drives the decode stage through a valid/ready handshake as pc, instruction, branch-prediction flag and predicted target. It sits directly upstream of decode. It handles pipeline-flush redirects and, when configured, static backward-taken/forward-not-taken (BTFN) redirects, dropping in-flight responses made stale by either.

## Interface
- RESET_VECTOR, 64'h0000_0000_8000_0000: first fetch address after reset.
- FIFO_DEPTH, 4: fetch buffer entries; power of two, ≥2. Also bounds in-flight requests.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- pipe_flush  in  1  redirect fetch to pipe_flush_pc; kill buffered and in-flight work.
- pipe_flush_pc  in  64  redirect target.
- im_req_addr  out  64  fetch address; 4-byte aligned.
- im_req_valid  out  1  request valid; may be withdrawn or changed before acceptance.
- im_req_ready  in  1  memory accepts the request when valid && ready.
- im_resp_rdata  in  32  instruction word.
- im_resp_valid  in  1  response, in request order, ≥1 cycle after acceptance; no backpressure.
- if_dec_pc  out  64  pc of the FIFO head.
- if_dec_instr  out  32  instruction of the FIFO head.
- if_dec_bp  out  1  head predicted taken.
- if_dec_bt  out  64  head predicted next pc.
- if_dec_valid  out  1  FIFO non-empty.
- if_dec_ready  in  1  decode consumes the head when valid && ready.

## Operation
- Registers:
  - fetch_pc.
  - inflight: accepted requests whose responses are not yet received, including doomed ones.
  - discard: responses still to be dropped.
  - FIFO of {pc, instr, bp, bt} with count.
  - pc_q: a small FIFO of issued addresses, depth FIFO_DEPTH, pushed on acceptance and popped on response.
- im_req_valid = !rst && (inflight + count < FIFO_DEPTH), using registered values. On acceptance, fetch_pc += 4 (64-bit wrap) and inflight increments.
- im_req_addr = fetch_pc.
- Response handling:
  - Response with discard > 0: dropped, discard decrements.
  - Otherwise enqueued with pc from pc_q; space is guaranteed by the credit rule.
- pipe_flush (highest priority):
  - fetch_pc <= pipe_flush_pc; FIFO cleared.
  - discard <= inflight after this cycle's acceptance and response, i.e. a request accepted in the flush cycle is also discarded and a response arriving in the flush cycle is dropped.
- Same-cycle events: dequeue, enqueue, acceptance and response may all occur in one cycle. The counters apply the net effect.

## Timing
- Reset values:
  - im_req_valid 0, if_dec_valid 0, count 0, inflight 0, discard 0.
  - fetch_pc = RESET_VECTOR; if_dec_bp 0, if_dec_bt 0.
- First request is asserted in the cycle after rst deasserts.
- Latency: a response in cycle N presents at if_dec_valid in cycle N+1. With 1-cycle memory, steady throughput is 1 instruction/cycle.
- FIFO full: im_req_valid stays low until a dequeue frees credit (registered, 1-cycle delay).
- FIFO empty: if_dec_valid is 0; the if_dec_* data outputs are don't-care.
- rst mid-operation: all state returns to reset values. Memory is reset concurrently, so no pending responses are expected afterwards.

## Configuration
- IFU_BTFN_EN defined:
  - Each enqueued response is predecoded.
  - JAL (opcode 1101111) is predicted taken.
  - B-type (1100011) with imm[12]=1 is predicted taken.
  - Predicted taken: bp=1, bt=pc+sext(imm).
  - Redirect on a taken enqueue (unless pipe_flush): fetch_pc <= bt. discard <= inflight remaining after this cycle, including any request accepted this cycle. Older FIFO entries are kept.
- IFU_BTFN_EN undefined: bp=0, bt=pc+4 always; no internal redirect.

## Structure
- Shared package:
  - RISC-V opcode constants OPCODE_JAL and OPCODE_BRANCH.
  - Fetch-entry struct {pc, instr, bp, bt}.
- Sub-module ifu_fifo: a generic synchronous FIFO instantiated for entries, also used for pc_q.
- Predecode stays inline in ifu.

## Test plan
- Reset release, memory always ready with 1-cycle response, decode always ready -> requests 0x80000000, 0x80000004, … on consecutive cycles. First if_dec_valid 2 cycles after the first request; then 1 instruction/cycle.
- if_dec_ready held 0 for 10 cycles -> exactly 4 entries buffered, im_req_valid low, no response lost. On release, pcs continue in order without gaps.
- Memory with 3-cycle latency, pipe_flush to 0x80001000 while 2 requests are in flight -> both stale responses dropped. Next if_dec_pc = 0x80001000.
- pipe_flush in the same cycle as a request acceptance and a response -> both dropped; no stale instruction reaches decode.
- IFU_BTFN_EN, instr 0xFE000EE3 (beq x0,x0,-4) at 0x80000008 -> bp=1, bt=0x80000004. The following fetch is 0x80000004; responses for 0x8000000C/0x80000010 are dropped.
- IFU_BTFN_EN undefined, same program -> bp=0, bt=0x8000000C; fetch continues sequentially.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: opcode constants and fetch-entry type shared by the instruction fetch unit
package ifu_pkg;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        bp;
    logic [63:0] bt;
  } fetch_entry_t;
endpackage

// File: rtl/ifu_if.sv
// ifu_if: flush, instruction-memory and decode handshake signals of the fetch unit
interface ifu_if;
  logic        pipe_flush;
  logic [63:0] pipe_flush_pc;
  logic [63:0] im_req_addr;
  logic        im_req_valid;
  logic        im_req_ready;
  logic [31:0] im_resp_rdata;
  logic        im_resp_valid;
  logic [63:0] if_dec_pc;
  logic [31:0] if_dec_instr;
  logic        if_dec_bp;
  logic [63:0] if_dec_bt;
  logic        if_dec_valid;
  logic        if_dec_ready;
  modport master (
    input  pipe_flush, pipe_flush_pc, im_req_ready, im_resp_rdata, im_resp_valid, if_dec_ready,
    output im_req_addr, im_req_valid, if_dec_pc, if_dec_instr, if_dec_bp, if_dec_bt, if_dec_valid
  );
  modport slave (
    output pipe_flush, pipe_flush_pc, im_req_ready, im_resp_rdata, im_resp_valid, if_dec_ready,
    input  im_req_addr, im_req_valid, if_dec_pc, if_dec_instr, if_dec_bp, if_dec_bt, if_dec_valid
  );
endinterface

// File: rtl/ifu_fifo.sv
// ifu_fifo: generic synchronous FIFO with clear; caller guarantees no push when full without pop
module ifu_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/ifu.sv
// ifu: sequential instruction fetch with flush redirect; define IFU_BTFN_EN for static BTFN prediction
module ifu
  import ifu_pkg::*;
#(
  parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_8000_0000,
  parameter int          FIFO_DEPTH   = 4
) (
  input logic   clk,
  input logic   rst,
  ifu_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [63:0]   fetch_pc, resp_pc, bt;
  logic [CW-1:0] inflight, inflight_nxt, discard, count;
  logic          accept, drop, enq, deq, taken, redirect;
  logic [31:0]   instr;
  fetch_entry_t  entry, head;
  // pc_q occupancy is exactly the number of outstanding requests
  assign bus.im_req_valid = !rst && ({1'b0, inflight} + {1'b0, count} < (CW+1)'(FIFO_DEPTH));
  assign bus.im_req_addr  = fetch_pc;
  assign accept = bus.im_req_valid && bus.im_req_ready;
  assign drop   = bus.im_resp_valid && discard != '0;
  assign enq    = bus.im_resp_valid && !drop && !bus.pipe_flush;
  assign deq    = bus.if_dec_valid && bus.if_dec_ready;
  assign inflight_nxt = inflight + CW'(accept) - CW'(bus.im_resp_valid);
  assign instr  = bus.im_resp_rdata;
`ifdef IFU_BTFN_EN
  logic [63:0] imm;
  assign taken = instr[6:0] == OPCODE_JAL || (instr[6:0] == OPCODE_BRANCH && instr[31]);
  assign imm = instr[6:0] == OPCODE_JAL
    ? {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
    : {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign bt       = resp_pc + (taken ? imm : 64'd4);
  assign redirect = enq && taken;
`else
  assign taken    = 1'b0;
  assign bt       = resp_pc + 64'd4;
  assign redirect = 1'b0;
`endif
  assign entry = '{pc: resp_pc, instr: instr, bp: taken, bt: bt};
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_VECTOR;
      discard  <= '0;
    end else begin
      fetch_pc <= bus.pipe_flush ? bus.pipe_flush_pc : redirect ? bt : accept ? fetch_pc + 64'd4 : fetch_pc;
      discard  <= (bus.pipe_flush || redirect) ? inflight_nxt : discard - CW'(drop);
    end
  end
  ifu_fifo #(.W(64), .DEPTH(FIFO_DEPTH)) u_pc_q (
    .clk(clk), .rst(rst), .clr(1'b0),
    .push(accept), .pop(bus.im_resp_valid),
    .din(fetch_pc), .dout(resp_pc), .count(inflight)
  );
  ifu_fifo #(.W($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_buf (
    .clk(clk), .rst(rst), .clr(bus.pipe_flush),
    .push(enq), .pop(deq),
    .din(entry), .dout(head), .count(count)
  );
  assign bus.if_dec_valid = count != '0;
  assign bus.if_dec_pc    = head.pc;
  assign bus.if_dec_instr = head.instr;
  assign bus.if_dec_bp    = bus.if_dec_valid && head.bp;
  assign bus.if_dec_bt    = bus.if_dec_valid ? head.bt : '0;
endmodule
